// File: rtl/sd_track_scheduler_pkg.sv
// Shared types and constants for the SD track scheduler.
// Each requester owns a fixed 32 MiB region; TRACK_BLOCKS only sets where its block pointer wraps.
package sd_track_scheduler_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_BUSY,
      S_XFER,
      S_DONE
   } sched_state_t;

   localparam int SD_ADDR_WIDTH   = 32;
   localparam int BLOCK_BYTES_DEF = 512;
   localparam int TRACK_BYTES     = 1 << 25;

endpackage

// File: rtl/sd_track_scheduler_if.sv
// Scheduler <-> SD block controller handshake.
// The master modport is the scheduler side.
interface sd_track_scheduler_if #(parameter int WORD_WIDTH = 8);
   import sd_track_scheduler_pkg::*;

   logic                     sd_ready;
   logic                     sd_rd;
   logic                     sd_wr;
   logic [SD_ADDR_WIDTH-1:0] sd_addr;
   logic [WORD_WIDTH-1:0]    sd_din;
   logic                     sd_ready_for_next_byte;
   logic [WORD_WIDTH-1:0]    sd_dout;
   logic                     sd_byte_available;

   modport master (
      input  sd_ready, sd_ready_for_next_byte, sd_dout, sd_byte_available,
      output sd_rd, sd_wr, sd_addr, sd_din
   );

   modport slave (
      output sd_ready, sd_ready_for_next_byte, sd_dout, sd_byte_available,
      input  sd_rd, sd_wr, sd_addr, sd_din
   );

endinterface

// File: rtl/sd_track_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after 'last', wrapping.
module sd_track_scheduler_rr_arbiter #(
   parameter int N  = 9,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] index,
   output logic          any
);

   logic [IW-1:0] cand;
   logic          found;

   always_comb begin
      grant = '0;
      index = '0;
      found = 1'b0;
      cand  = '0;
      for (int k = 1; k <= N; k++) begin
         cand = IW'((int'(last) + k) % N);
         if (!found && req[cand]) begin
            found        = 1'b1;
            index        = cand;
            grant[cand]  = 1'b1;
         end
      end
      any = found;
   end

endmodule

// File: rtl/sd_track_scheduler.sv
// Round-robin scheduler sharing one SD block controller between track streams,
// one 512-byte block per grant, with per-track circular block pointers.
//
// state       | meaning
// S_IDLE      | waiting for sd_ready and any request; arbitrate and latch address
// S_ISSUE     | sd_rd / sd_wr pulse visible for this single cycle
// S_WAIT_BUSY | waiting for the controller to drop sd_ready
// S_XFER      | counting byte strobes up to BLOCK_BYTES
// S_DONE      | waiting for sd_ready, then pulse done and advance pointer
module sd_track_scheduler
   import sd_track_scheduler_pkg::*;
#(
   parameter int REQUESTERS   = 9,
   parameter int WORD_WIDTH   = 8,
   parameter int BLOCK_BYTES  = BLOCK_BYTES_DEF,
   parameter int TRACK_BLOCKS = 65536
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [SD_ADDR_WIDTH-1:0]         base_addr,
   input  logic                             restart,
   input  logic [REQUESTERS-1:0]            req,
   input  logic [REQUESTERS-1:0]            req_wr,
   input  logic [REQUESTERS*WORD_WIDTH-1:0] wr_data,
   output logic [REQUESTERS-1:0]            wr_pop,
   output logic [WORD_WIDTH-1:0]            rd_data,
   output logic [REQUESTERS-1:0]            rd_valid,
   output logic [REQUESTERS-1:0]            grant,
   output logic [REQUESTERS-1:0]            done,
   output logic                             busy,
   sd_track_scheduler_if.master             sd
);

   localparam int IW = $clog2(REQUESTERS);
   localparam int CW = $clog2(BLOCK_BYTES) + 1;
   localparam int PW = (TRACK_BLOCKS > 1) ? $clog2(TRACK_BLOCKS) : 1;

   sched_state_t           state;
   logic [IW-1:0]          last;
   logic [IW-1:0]          owner;
   logic                   dir_wr;
   logic                   restart_pend;
   logic [CW-1:0]          byte_cnt;
   logic [PW-1:0]          ptr [REQUESTERS];
   logic [WORD_WIDTH-1:0]  wr_bytes [REQUESTERS];

   logic [REQUESTERS-1:0]    arb_grant;
   logic [IW-1:0]            arb_index;
   logic                     arb_any;
   logic [SD_ADDR_WIDTH-1:0] next_addr;
   logic                     cnt_live;
   logic                     xfer_strobe;
   logic                     advance;

   sd_track_scheduler_rr_arbiter #(.N(REQUESTERS), .IW(IW)) u_arb (
      .req   (req),
      .last  (last),
      .grant (arb_grant),
      .index (arb_index),
      .any   (arb_any)
   );

   for (genvar gi = 0; gi < REQUESTERS; gi++) begin : g_unpack
      assign wr_bytes[gi] = wr_data[gi*WORD_WIDTH +: WORD_WIDTH];
   end

   assign next_addr   = base_addr
                      + 32'(arb_index) * 32'(TRACK_BYTES)
                      + 32'(ptr[arb_index]) * 32'(BLOCK_BYTES);
   assign cnt_live    = (state == S_XFER) && (byte_cnt < CW'(BLOCK_BYTES));
   assign xfer_strobe = dir_wr ? sd.sd_ready_for_next_byte : sd.sd_byte_available;
   assign busy        = (state != S_IDLE);
   assign wr_pop      = (cnt_live && dir_wr && sd.sd_ready_for_next_byte) ? grant : '0;
   assign sd.sd_din   = (|grant) ? wr_bytes[owner] : '0;

   // A restart seen at any point of the in-flight block suppresses its advance.
   assign advance     = (state == S_DONE) && sd.sd_ready && !restart && !restart_pend;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < REQUESTERS; i++) ptr[i] <= '0;
      end else if (restart) begin
         for (int i = 0; i < REQUESTERS; i++) ptr[i] <= '0;
      end else if (advance) begin
         ptr[owner] <= (ptr[owner] == PW'(TRACK_BLOCKS - 1)) ? '0 : ptr[owner] + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         last         <= IW'(REQUESTERS - 1);
         owner        <= '0;
         dir_wr       <= 1'b0;
         restart_pend <= 1'b0;
         byte_cnt     <= '0;
         grant        <= '0;
         done         <= '0;
         rd_valid     <= '0;
         rd_data      <= '0;
         sd.sd_rd     <= 1'b0;
         sd.sd_wr     <= 1'b0;
         sd.sd_addr   <= '0;
      end else begin
         done     <= '0;
         rd_valid <= '0;
         sd.sd_rd <= 1'b0;
         sd.sd_wr <= 1'b0;
         if (state != S_IDLE && restart) restart_pend <= 1'b1;
         case (state)
            S_IDLE: begin
               restart_pend <= restart;
               if (sd.sd_ready && arb_any) begin
                  owner      <= arb_index;
                  grant      <= arb_grant;
                  dir_wr     <= |(req_wr & arb_grant);
                  sd.sd_wr   <= |(req_wr & arb_grant);
                  sd.sd_rd   <= ~|(req_wr & arb_grant);
                  sd.sd_addr <= next_addr;
                  byte_cnt   <= '0;
                  state      <= S_ISSUE;
               end
            end
            S_ISSUE: state <= S_WAIT_BUSY;
            S_WAIT_BUSY: if (!sd.sd_ready) state <= S_XFER;
            S_XFER: begin
               if (cnt_live && xfer_strobe) begin
                  byte_cnt <= byte_cnt + 1'b1;
                  if (!dir_wr) begin
                     rd_data  <= sd.sd_dout;
                     rd_valid <= grant;
                  end
                  if (byte_cnt == CW'(BLOCK_BYTES - 1)) state <= S_DONE;
               end
            end
            S_DONE: begin
               if (sd.sd_ready) begin
                  done  <= grant;
                  grant <= '0;
                  last  <= owner;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/sd_track_scheduler.md
Name: sd_track_scheduler

Overview:
- Time-multiplexes the single SD card block controller between REQUESTERS track streams (playback channels plus one record stream).
- Each requester owns a fixed 32 MiB track region.
- Round-robin arbitration; one 512-byte block read or write per grant; per-track block pointers maintained internally.
- Sits between the per-channel track FIFOs and the SD controller, in the 100 MHz domain, replacing ad-hoc store/load sequencing.

Parameters:
- REQUESTERS, 9: number of streams (indices 0..7 playback, 8 record by convention).
- WORD_WIDTH, 8: byte width of SD data path.
- BLOCK_BYTES, 512: bytes per SD block transfer.
- TRACK_BLOCKS, 65536: blocks per track region (TRACK_BYTES = BLOCK_BYTES*TRACK_BLOCKS = 2^25).

Ports:
- clk  in  1  single system clock (100 MHz domain).
- rst  in  1  asynchronous, active-high reset.
- base_addr  in  32  byte address of track 0; track i base = base_addr + i*TRACK_BYTES.
- restart  in  1  pulse: zero all block pointers.
- req  in  REQUESTERS  level request per stream.
- req_wr  in  REQUESTERS  1 = write (record), 0 = read (playback); sampled at grant.
- wr_data  in  REQUESTERS*WORD_WIDTH  packed FWFT FIFO heads.
- wr_pop  out  REQUESTERS  one-hot pop strobe to the granted write FIFO.
- rd_data  out  WORD_WIDTH  registered read byte.
- rd_valid  out  REQUESTERS  one-hot strobe qualifying rd_data.
- grant  out  REQUESTERS  one-hot owner from ISSUE through DONE.
- done  out  REQUESTERS  one-cycle pulse at block completion.
- busy  out  1  high whenever state != IDLE.
- sd_ready  in  1  controller idle.
- sd_rd, sd_wr  out  1  one-cycle command pulses.
- sd_addr  out  32  block byte address, held from ISSUE to DONE.
- sd_din  out  WORD_WIDTH  write byte.
- sd_ready_for_next_byte  in  1  write byte strobe.
- sd_dout  in  WORD_WIDTH  read byte.
- sd_byte_available  in  1  read byte strobe.

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; pointers 0; round-robin last = REQUESTERS-1.
- States:
  - IDLE: if sd_ready and |req, pick first set req after last (wrapping); register grant, dir, and sd_addr = base_i + ptr_i*BLOCK_BYTES; go to ISSUE.
  - ISSUE: sd_rd or sd_wr = 1 for exactly one cycle; go to WAIT_BUSY.
  - WAIT_BUSY: wait for sd_ready = 0; go to XFER.
  - XFER: count byte strobes until BLOCK_BYTES; go to DONE.
  - DONE: wait for sd_ready = 1; pulse done[g]; advance ptr_g; last = g; go to IDLE.
- Read path: on sd_byte_available in XFER, rd_data <= sd_dout and rd_valid[g] <= 1 on the next cycle (latency 1).
- Write path: sd_din = wr_data[g] combinationally; wr_pop[g] = sd_ready_for_next_byte & XFER (same cycle).
- Byte counter is $clog2(BLOCK_BYTES)+1 bits. Strobes after the count reaches BLOCK_BYTES are ignored: no pop, no valid.
- Pointer wrap: ptr_g == TRACK_BLOCKS-1 advances to 0, so the track region is circular. Address arithmetic is 32-bit unsigned, modulo 2^32.
- Dropping req during a transfer has no effect; the block always completes.
- restart while busy: pointers zeroed, but the in-flight block still completes without advancing its pointer, so the next access uses offset 0.
- restart coincident with DONE advance: restart wins.
- Grant latency from req with the scheduler idle: 1 cycle (IDLE -> ISSUE).
- Back-to-back requests: minimum 1 IDLE cycle between blocks.
- Reset mid-transfer aborts immediately and leaves the SD controller partial. The SD controller shares rst and must be reset together.

Decomposition:
- daw_pkg: sched_state_t enum (IDLE, ISSUE, WAIT_BUSY, XFER, DONE), SD_ADDR_WIDTH = 32, BLOCK_BYTES default constant.
- Sub-module rr_arbiter: purely combinational. Inputs req and last; outputs one-hot grant and index. Verified standalone.

Test Plan:
- Reset then req[2]=1 read, base_addr=0 -> sd_addr=0x0400_0000, one sd_rd pulse, 512 rd_valid[2] pulses, done[2]; next grant on req[2] gives sd_addr=0x0400_0200.
- req[0], req[3], req[8] held high -> grant order 0,3,8,0,3; no grant gaps beyond 1 IDLE cycle.
- req[8] write with FIFO holding 0..255,0..255 -> exactly 512 wr_pop[8], sd_din sequence matches, extra 513th sd_ready_for_next_byte strobe produces no pop.
- TRACK_BLOCKS=4, req[1] for 5 blocks, base_addr=0x1000_0000 -> addresses +0,+0x200,+0x400,+0x600,+0 relative to 0x1200_0000.
- restart pulsed mid-XFER of req[5] block 3 -> block completes with done[5], next req[5] address = track 5 base.
- rst asserted mid-XFER -> all outputs 0 in the same cycle (asynchronous), busy=0, and the next grant goes to the lowest requesting index.
